pim_req_arbiter: RTL and testbench
==================================

Name: pim_req_arbiter

Overview:
- Shares the single request/response port of the DDR3 PIM DRAM controller between NUM_REQ requesters (host cores / DMA).
- Row-hit-first scheduling: keeps a shadow open-row table using the controller's address map, prefers requests that hit a shadowed open row, otherwise round-robin.
- A bypass cap bounds starvation.
- One transaction in flight at a time, matching the controller's serialized FSM. Responses route back to the issuing requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width, equal to clog2(NUM_REQ).
- MAX_BYPASS, 4, consecutive row-hit picks allowed to override the round-robin choice.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_req_valid  in  NUM_REQ  per-requester request valid.
- s_req_ready  out  NUM_REQ  per-requester accept pulse.
- s_req_addr  in  NUM_REQ*32  packed addresses; requester k uses bits [32k+31:32k].
- s_resp_valid  out  NUM_REQ  per-requester response valid.
- s_resp_ready  in  NUM_REQ  per-requester response ready.
- s_resp_data  out  512  response data, shared by all requesters, valid only with the asserted s_resp_valid bit.
- m_req_valid  out  1  request to controller.
- m_req_ready  in  1  controller accept.
- m_req_addr  out  32  forwarded address.
- m_resp_valid  in  1  controller response valid.
- m_resp_ready  out  1  accept controller response.
- m_resp_data  in  512  controller response data.
- grant_count  out  32  total grants issued.
- hit_grant_count  out  32  grants chosen by the row-hit rule over the round-robin choice.

Behaviour:
- Address map, identical to the controller: bank = addr[12:10], row = addr[25:13]. Shadow table: 8 × {valid, row[12:0]}.
- Reset (rst=1 at posedge):
  - state=IDLE; all outputs 0.
  - rr_ptr=0, bypass_cnt=0, all shadow valid=0, both counters 0.
  - rst mid-transaction abandons the transaction. The controller must be reset together with this block.
- State IDLE:
  - hit set = valid requesters whose bank is shadow-valid with an equal row.
  - rr_pick = first valid requester at or after rr_ptr, circular.
  - If the hit set is non-empty and bypass_cnt < MAX_BYPASS: pick = first member of the hit set at or after rr_ptr.
  - Otherwise pick = rr_pick.
  - If any request is valid:
    - s_req_ready[pick]=1 for exactly this cycle (registered, so the pulse appears the cycle after the decision; the requester holds valid/addr until it sees ready).
    - Latch gid=pick and gaddr.
    - grant_count++.
    - If pick != rr_pick: hit_grant_count++ and bypass_cnt++; else bypass_cnt=0.
    - rr_ptr = pick+1 mod NUM_REQ.
    - Shadow[bank] = {1, row}.
    - Go to ISSUE.
  - No valid request: stay in IDLE, no change.
- State ISSUE: m_req_valid=1, m_req_addr=gaddr, held stable until m_req_ready=1 is sampled; then m_req_valid=0 and go to WAIT.
- State WAIT: m_resp_ready=1. When m_resp_valid=1 is sampled: capture m_resp_data into rbuf, m_resp_ready=0, go to RETURN.
- State RETURN: s_resp_valid[gid]=1 (one-hot), s_resp_data=rbuf, held until s_resp_ready[gid]=1 is sampled; then clear and go to IDLE.
- Minimum turnaround: IDLE→ISSUE→WAIT→RETURN→IDLE. Arbiter overhead is 3 cycles beyond controller latency.
- Shadow table is a hint only:
  - Metadata-skipped requests leave controller rows untouched, so the shadow may diverge from the controller.
  - Divergence affects only the scheduling choice, never correctness.
- Counters wrap at 2^32.
- Requests deasserted before their grant are legal and are simply not picked.
- s_resp_valid bits other than gid are always 0.

Decomposition:
- Shared package pim_ctrl_pkg holds:
  - address-map constants: BANK_LSB=10, BANK_W=3, ROW_LSB=13, ROW_W=13, NUM_BANKS=8;
  - the arbiter state enum {IDLE, ISSUE, WAIT, RETURN};
  - the DATA_W=512 constant.
- One sub-module: rr_hit_picker. Purely combinational; takes the valid vector, hit vector, rr_ptr and bypass_cnt, and produces pick, rr_pick and a use-hit flag. It is reusable by a future multi-channel scheduler.

Test Plan:
- Single requester 0, addr 0x0000_2400 (bank 1, row 1), controller returns data 0xABCD → s_resp_valid[0] with data 0xABCD; grant_count=1, hit_grant_count=0; shadow bank1=row1.
- All 4 requesters valid, distinct banks, no shadow hits → grant order 0,1,2,3,0; rr_ptr wraps; hit_grant_count=0.
- Shadow bank1=row1 and rr_ptr=0; requester 0 at addr 0x0000_4400 (bank1, row2), requester 2 at 0x0000_2400 (hit) → requester 2 granted first; hit_grant_count=1.
- Requester 3 repeatedly hits bank1/row1 while requester 0 stays valid with a miss → requester 3 gets 4 bypass grants, the 5th grant goes to requester 0, bypass_cnt resets to 0.
- m_req_ready held low for 10 cycles, then m_resp_valid arrives while s_resp_ready[gid]=0 for 5 cycles → m_req_addr stable throughout; s_resp_valid held 5 cycles; no new grant until acceptance.
- rst asserted during WAIT → next cycle all outputs 0, state IDLE, counters 0, shadow cleared.

Source files
------------

// File: rtl/pim_ctrl_pkg.sv
// Shared definitions for the DDR3 PIM controller front end: address map,
// arbiter state encoding and data width.
package pim_ctrl_pkg;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 512;
   localparam int BANK_LSB  = 10;
   localparam int BANK_W    = 3;
   localparam int ROW_LSB   = 13;
   localparam int ROW_W     = 13;
   localparam int NUM_BANKS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      RETURN = 2'd3
   } arb_state_e;

   function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
      return addr[BANK_LSB +: BANK_W];
   endfunction

   function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
      return addr[ROW_LSB +: ROW_W];
   endfunction

endpackage

// File: rtl/pim_req_arbiter_if.sv
// Requester-side and controller-side handshake bundle of the PIM request arbiter.
// The slave view belongs to the arbiter; the master view to requesters plus controller.
interface pim_req_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   import pim_ctrl_pkg::*;

   logic [NUM_REQ-1:0]        s_req_valid;
   logic [NUM_REQ-1:0]        s_req_ready;
   logic [NUM_REQ*ADDR_W-1:0] s_req_addr;
   logic [NUM_REQ-1:0]        s_resp_valid;
   logic [NUM_REQ-1:0]        s_resp_ready;
   logic [DATA_W-1:0]         s_resp_data;
   logic                      m_req_valid;
   logic                      m_req_ready;
   logic [ADDR_W-1:0]         m_req_addr;
   logic                      m_resp_valid;
   logic                      m_resp_ready;
   logic [DATA_W-1:0]         m_resp_data;

   modport slave (
      input  s_req_valid, s_req_addr, s_resp_ready, m_req_ready, m_resp_valid, m_resp_data,
      output s_req_ready, s_resp_valid, s_resp_data, m_req_valid, m_req_addr, m_resp_ready
   );

   modport master (
      output s_req_valid, s_req_addr, s_resp_ready, m_req_ready, m_resp_valid, m_resp_data,
      input  s_req_ready, s_resp_valid, s_resp_data, m_req_valid, m_req_addr, m_resp_ready
   );

endinterface

// File: rtl/pim_req_arbiter_picker.sv
// Combinational row-hit-first / round-robin selector, independent of the
// address map so a multi-channel scheduler can reuse it.
module rr_hit_picker #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int MAX_BYPASS = 4,
   parameter int CNT_W      = 3
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] hit,
   input  logic [ID_W-1:0]    rr_ptr,
   input  logic [CNT_W-1:0]   bypass_cnt,
   output logic [ID_W-1:0]    pick,
   output logic [ID_W-1:0]    rr_pick,
   output logic               use_hit
);

   logic [ID_W-1:0] idx_s;
   logic [ID_W-1:0] hit_pick_s;
   logic            rr_found_s;
   logic            hit_found_s;

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      return (s >= NUM_REQ) ? ID_W'(s - NUM_REQ) : ID_W'(s);
   endfunction

   // Circular scan from rr_ptr: first valid and first hitting requester.
   always_comb begin
      idx_s       = '0;
      rr_pick     = '0;
      hit_pick_s  = '0;
      rr_found_s  = 1'b0;
      hit_found_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s       = wrap_idx(rr_ptr, i);
         rr_pick     = (!rr_found_s && valid[idx_s]) ? idx_s : rr_pick;
         rr_found_s  = rr_found_s | valid[idx_s];
         hit_pick_s  = (!hit_found_s && hit[idx_s]) ? idx_s : hit_pick_s;
         hit_found_s = hit_found_s | hit[idx_s];
      end
   end

   assign use_hit = hit_found_s && (bypass_cnt < CNT_W'(MAX_BYPASS));
   assign pick    = use_hit ? hit_pick_s : rr_pick;

endmodule

// File: rtl/pim_req_arbiter.sv
// Shares the single PIM DRAM controller port among NUM_REQ requesters with
// row-hit-first scheduling, a bounded bypass count and one transaction in flight.
module pim_req_arbiter
   import pim_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int MAX_BYPASS = 4
) (
   input  logic        clk,
   input  logic        rst,
   pim_req_arbiter_if.slave bus,
   output logic [31:0] grant_count,
   output logic [31:0] hit_grant_count
);

   localparam int CNT_W = $clog2(MAX_BYPASS + 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_e           state_r, state_nxt_s;
   logic [ID_W-1:0]      rr_ptr_r, rr_ptr_nxt_s;
   logic [CNT_W-1:0]     bypass_cnt_r, bypass_cnt_nxt_s;
   logic [ID_W-1:0]      gid_r, gid_nxt_s;
   logic [ADDR_W-1:0]    gaddr_r, gaddr_nxt_s;
   logic [DATA_W-1:0]    rbuf_r, rbuf_nxt_s;
   logic [NUM_REQ-1:0]   s_req_ready_r, s_req_ready_nxt_s;
   logic [NUM_REQ-1:0]   s_resp_valid_r, s_resp_valid_nxt_s;
   logic                 m_req_valid_r, m_req_valid_nxt_s;
   logic                 m_resp_ready_r, m_resp_ready_nxt_s;
   logic [31:0]          gc_r, gc_nxt_s;
   logic [31:0]          hgc_r, hgc_nxt_s;
   logic [NUM_BANKS-1:0] shadow_valid_r;
   logic [ROW_W-1:0]     shadow_row_r [NUM_BANKS];
   logic                 shadow_we_s;

   logic [ADDR_W-1:0]    req_addr_s [NUM_REQ];
   logic [NUM_REQ-1:0]   hit_s;
   logic [ID_W-1:0]      pick_s, rr_pick_s;
   logic                 use_hit_s;

   // Split the packed address bus and flag requests that hit a shadowed open row.
   always_comb begin
      hit_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_addr_s[k] = bus.s_req_addr[k*ADDR_W +: ADDR_W];
         hit_s[k] = bus.s_req_valid[k]
                  & shadow_valid_r[addr_bank(req_addr_s[k])]
                  & (shadow_row_r[addr_bank(req_addr_s[k])] == addr_row(req_addr_s[k]));
      end
   end

   rr_hit_picker #(
      .NUM_REQ   (NUM_REQ),
      .ID_W      (ID_W),
      .MAX_BYPASS(MAX_BYPASS),
      .CNT_W     (CNT_W)
   ) u_picker (
      .valid     (bus.s_req_valid),
      .hit       (hit_s),
      .rr_ptr    (rr_ptr_r),
      .bypass_cnt(bypass_cnt_r),
      .pick      (pick_s),
      .rr_pick   (rr_pick_s),
      .use_hit   (use_hit_s)
   );

   // Next-state and next-output decode of the serialized transaction FSM.
   always_comb begin
      state_nxt_s        = state_r;
      rr_ptr_nxt_s       = rr_ptr_r;
      bypass_cnt_nxt_s   = bypass_cnt_r;
      gid_nxt_s          = gid_r;
      gaddr_nxt_s        = gaddr_r;
      rbuf_nxt_s         = rbuf_r;
      s_req_ready_nxt_s  = '0;
      s_resp_valid_nxt_s = s_resp_valid_r;
      m_req_valid_nxt_s  = m_req_valid_r;
      m_resp_ready_nxt_s = m_resp_ready_r;
      gc_nxt_s           = gc_r;
      hgc_nxt_s          = hgc_r;
      shadow_we_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (|bus.s_req_valid) begin
               s_req_ready_nxt_s = ONE_HOT0 << pick_s;
               gid_nxt_s         = pick_s;
               gaddr_nxt_s       = req_addr_s[pick_s];
               gc_nxt_s          = gc_r + 32'd1;
               // A hit pick that coincides with the round-robin pick is not a bypass.
               if (pick_s != rr_pick_s) begin
                  hgc_nxt_s        = hgc_r + 32'd1;
                  bypass_cnt_nxt_s = bypass_cnt_r + CNT_W'(1);
               end else begin
                  bypass_cnt_nxt_s = '0;
               end
               rr_ptr_nxt_s      = (pick_s == ID_W'(NUM_REQ - 1)) ? '0 : pick_s + ID_W'(1);
               shadow_we_s       = 1'b1;
               m_req_valid_nxt_s = 1'b1;
               state_nxt_s       = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (bus.m_req_ready) begin
               m_req_valid_nxt_s  = 1'b0;
               m_resp_ready_nxt_s = 1'b1;
               state_nxt_s        = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            if (bus.m_resp_valid) begin
               rbuf_nxt_s         = bus.m_resp_data;
               m_resp_ready_nxt_s = 1'b0;
               s_resp_valid_nxt_s = ONE_HOT0 << gid_r;
               state_nxt_s        = RETURN;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RETURN: begin
            if (bus.s_resp_ready[gid_r]) begin
               s_resp_valid_nxt_s = '0;
               state_nxt_s        = IDLE;
            end else begin
               state_nxt_s = RETURN;
            end
         end
         default: begin
            s_resp_valid_nxt_s = '0;
            m_req_valid_nxt_s  = 1'b0;
            m_resp_ready_nxt_s = 1'b0;
            state_nxt_s        = IDLE;
         end
      endcase
   end

   // State, registered outputs, counters and the open-row shadow table.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         rr_ptr_r       <= '0;
         bypass_cnt_r   <= '0;
         gid_r          <= '0;
         gaddr_r        <= '0;
         rbuf_r         <= '0;
         s_req_ready_r  <= '0;
         s_resp_valid_r <= '0;
         m_req_valid_r  <= 1'b0;
         m_resp_ready_r <= 1'b0;
         gc_r           <= 32'd0;
         hgc_r          <= 32'd0;
         shadow_valid_r <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            shadow_row_r[b] <= '0;
         end
      end else begin
         state_r        <= state_nxt_s;
         rr_ptr_r       <= rr_ptr_nxt_s;
         bypass_cnt_r   <= bypass_cnt_nxt_s;
         gid_r          <= gid_nxt_s;
         gaddr_r        <= gaddr_nxt_s;
         rbuf_r         <= rbuf_nxt_s;
         s_req_ready_r  <= s_req_ready_nxt_s;
         s_resp_valid_r <= s_resp_valid_nxt_s;
         m_req_valid_r  <= m_req_valid_nxt_s;
         m_resp_ready_r <= m_resp_ready_nxt_s;
         gc_r           <= gc_nxt_s;
         hgc_r          <= hgc_nxt_s;
         if (shadow_we_s) begin
            shadow_valid_r[addr_bank(gaddr_nxt_s)] <= 1'b1;
            shadow_row_r[addr_bank(gaddr_nxt_s)]   <= addr_row(gaddr_nxt_s);
         end
      end
   end

   assign bus.s_req_ready  = s_req_ready_r;
   assign bus.s_resp_valid = s_resp_valid_r;
   assign bus.s_resp_data  = rbuf_r;
   assign bus.m_req_valid  = m_req_valid_r;
   assign bus.m_req_addr   = gaddr_r;
   assign bus.m_resp_ready = m_resp_ready_r;
   assign grant_count      = gc_r;
   assign hit_grant_count  = hgc_r;

endmodule

// File: tb/tb_pim_req_arbiter.sv
// Directed table-driven bench for pim_req_arbiter with a small controller model,
// plus a hand-written reset-during-WAIT sequence.
module tb_pim_req_arbiter;
   import pim_ctrl_pkg::*;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gc, hgc;
   int          checks = 0;
   int          errors = 0;

   pim_req_arbiter_if #(.NUM_REQ(NR)) ifc ();

   pim_req_arbiter #(.NUM_REQ(NR), .ID_W(2), .MAX_BYPASS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (ifc.slave),
      .grant_count    (gc),
      .hit_grant_count(hgc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           rst_before;
      logic [NR-1:0]  valid;
      logic [127:0]   addrs;
      logic [31:0]    seed;
      int             gid;
      logic [31:0]    exp_gc;
      logic [31:0]    exp_hgc;
      int             req_stall;
      int             resp_stall;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic r, input logic [3:0] v,
                               input logic [31:0] a3, input logic [31:0] a2,
                               input logic [31:0] a1, input logic [31:0] a0,
                               input logic [31:0] seed, input int gid, input int egc,
                               input int ehgc, input int rs, input int ps);
      vec_t t;
      t.rst_before = r;
      t.valid      = v;
      t.addrs      = {a3, a2, a1, a0};
      t.seed       = seed;
      t.gid        = gid;
      t.exp_gc     = 32'(egc);
      t.exp_hgc    = 32'(ehgc);
      t.req_stall  = rs;
      t.resp_stall = ps;
      return t;
   endfunction

   function automatic logic [31:0] ra(input int row, input int bank);
      return 32'((row << 13) | (bank << 10));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                           input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_s_req_ready"},  32'(ifc.s_req_ready), 32'd0);
      chk({tag, "_s_resp_valid"}, 32'(ifc.s_resp_valid), 32'd0);
      chk({tag, "_m_req_valid"},  32'(ifc.m_req_valid), 32'd0);
      chk({tag, "_m_req_addr"},   ifc.m_req_addr, 32'd0);
      chk({tag, "_m_resp_ready"}, 32'(ifc.m_resp_ready), 32'd0);
      chk_data({tag, "_s_resp_data"}, ifc.s_resp_data, {DATA_W{1'b0}});
      chk({tag, "_grant_count"},  gc, 32'd0);
      chk({tag, "_hit_count"},    hgc, 32'd0);
   endtask

   // One full transaction: arbitration, controller handshake, response return.
   task automatic run_txn(input vec_t v, input string tag);
      logic [DATA_W-1:0] data;
      logic [31:0]       exp_addr;
      logic [NR-1:0]     exp_oh;
      bit                got;
      data     = {16{v.seed}};
      exp_addr = 32'(v.addrs >> (32 * v.gid));
      exp_oh   = 4'b0001 << v.gid;
      if (v.rst_before) do_reset();
      ifc.s_req_addr  = v.addrs;
      ifc.s_req_valid = v.valid;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(posedge clk); #1;
         got = |ifc.s_req_ready;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_grant_timeout: got no s_req_ready expected %0h", tag, exp_oh);
         ifc.s_req_valid = '0;
         return;
      end
      chk({tag, "_grant"}, 32'(ifc.s_req_ready), 32'(exp_oh));
      chk({tag, "_m_req_valid"}, 32'(ifc.m_req_valid), 32'd1);
      chk({tag, "_m_req_addr"}, ifc.m_req_addr, exp_addr);
      ifc.s_req_valid = '0;
      for (int c = 0; c < v.req_stall; c++) begin
         @(posedge clk); #1;
         chk({tag, "_stall_m_req_valid"}, 32'(ifc.m_req_valid), 32'd1);
         chk({tag, "_stall_m_req_addr"}, ifc.m_req_addr, exp_addr);
      end
      ifc.m_req_ready = 1'b1;
      @(posedge clk); #1;
      ifc.m_req_ready = 1'b0;
      chk({tag, "_ready_pulse_done"}, 32'(ifc.s_req_ready), 32'd0);
      chk({tag, "_m_req_dropped"}, 32'(ifc.m_req_valid), 32'd0);
      chk({tag, "_m_resp_ready"}, 32'(ifc.m_resp_ready), 32'd1);
      ifc.m_resp_valid = 1'b1;
      ifc.m_resp_data  = data;
      @(posedge clk); #1;
      ifc.m_resp_valid = 1'b0;
      chk({tag, "_m_resp_ready_low"}, 32'(ifc.m_resp_ready), 32'd0);
      chk({tag, "_s_resp_valid"}, 32'(ifc.s_resp_valid), 32'(exp_oh));
      chk_data({tag, "_s_resp_data"}, ifc.s_resp_data, data);
      for (int c = 0; c < v.resp_stall; c++) begin
         ifc.s_req_valid  = '1;
         ifc.s_resp_ready = ~exp_oh;
         @(posedge clk); #1;
         chk({tag, "_held_s_resp_valid"}, 32'(ifc.s_resp_valid), 32'(exp_oh));
         chk({tag, "_no_new_grant"}, 32'(ifc.s_req_ready), 32'd0);
      end
      ifc.s_req_valid  = '0;
      ifc.s_resp_ready = exp_oh;
      @(posedge clk); #1;
      ifc.s_resp_ready = '0;
      chk({tag, "_s_resp_cleared"}, 32'(ifc.s_resp_valid), 32'd0);
      chk({tag, "_grant_count"}, gc, v.exp_gc);
      chk({tag, "_hit_grant_count"}, hgc, v.exp_hgc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      // single grant, then 5-round round robin, hit preference, bypass cap, long stalls
      vecs[0]  = mk(1'b0, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0000_2400, 32'h0000_ABCD, 0, 1, 0, 0, 0);
      vecs[1]  = mk(1'b1, 4'b1111, ra(20,5), ra(20,4), ra(20,3), ra(20,2), 32'h1111_0001, 0, 1, 0, 0, 0);
      vecs[2]  = mk(1'b0, 4'b1111, ra(21,5), ra(21,4), ra(21,3), ra(21,2), 32'h1111_0002, 1, 2, 0, 0, 0);
      vecs[3]  = mk(1'b0, 4'b1111, ra(22,5), ra(22,4), ra(22,3), ra(22,2), 32'h1111_0003, 2, 3, 0, 0, 0);
      vecs[4]  = mk(1'b0, 4'b1111, ra(23,5), ra(23,4), ra(23,3), ra(23,2), 32'h1111_0004, 3, 4, 0, 0, 0);
      vecs[5]  = mk(1'b0, 4'b1111, ra(24,5), ra(24,4), ra(24,3), ra(24,2), 32'h1111_0005, 0, 5, 0, 0, 0);
      vecs[6]  = mk(1'b1, 4'b1000, 32'h0000_2400, 32'h0, 32'h0, 32'h0, 32'h2222_0001, 3, 1, 0, 0, 0);
      vecs[7]  = mk(1'b0, 4'b0101, 32'h0, 32'h0000_2400, 32'h0, 32'h0000_4400, 32'h2222_0002, 2, 2, 1, 0, 0);
      vecs[8]  = mk(1'b1, 4'b1000, 32'h0000_2400, 32'h0, 32'h0, 32'h0, 32'h3333_0001, 3, 1, 0, 0, 0);
      vecs[9]  = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0002, 3, 2, 1, 0, 0);
      vecs[10] = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0003, 3, 3, 2, 0, 0);
      vecs[11] = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0004, 3, 4, 3, 0, 0);
      vecs[12] = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0005, 3, 5, 4, 0, 0);
      vecs[13] = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0006, 0, 6, 4, 0, 0);
      vecs[14] = mk(1'b0, 4'b1001, 32'h0000_2400, 32'h0, 32'h0, 32'h0000_4400, 32'h3333_0007, 0, 7, 5, 0, 0);
      vecs[15] = mk(1'b0, 4'b0010, 32'h0, 32'h0, 32'h0000_8C00, 32'h0, 32'h4444_0001, 1, 8, 5, 10, 5);

      ifc.s_req_valid  = '0;
      ifc.s_req_addr   = '0;
      ifc.s_resp_ready = '0;
      ifc.m_req_ready  = 1'b0;
      ifc.m_resp_valid = 1'b0;
      ifc.m_resp_data  = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting for the controller response.
      ifc.s_req_addr  = {32'h0, 32'h0, 32'h0, 32'h0000_2400};
      ifc.s_req_valid = 4'b0001;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(posedge clk); #1;
         got = |ifc.s_req_ready;
      end
      chk("wait_rst_grant", 32'(ifc.s_req_ready), 32'd1);
      ifc.s_req_valid = '0;
      ifc.m_req_ready = 1'b1;
      @(posedge clk); #1;
      ifc.m_req_ready = 1'b0;
      chk("wait_rst_in_wait", 32'(ifc.m_resp_ready), 32'd1);
      do_reset();
      chk_idle_outputs("wait_rst");
      // Shadow must be empty: requester 2's former hit cannot win over rr choice 0.
      run_txn(mk(1'b0, 4'b0101, 32'h0, 32'h0000_2400, 32'h0, 32'h0000_4400,
                 32'h5555_0001, 0, 1, 0, 0, 0), "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
